eaglesong_absorb_feeder: RTL and testbench
==========================================

EAGLESONG_ABSORB_FEEDER -- requirements
Module: eaglesong_absorb_feeder

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 reset_n  in  1  synchronous, active-low reset.
REQ-003 in_valid  in  1  in_byte/in_last carry a message byte this cycle.
REQ-004 in_ready  out  1  feeder can accept a byte this cycle.
REQ-005 in_byte  in  8  message byte, in message order.
REQ-006 in_last  in  1  qualifies in_byte as the final byte of the message.
REQ-007 out_valid  out  1  a chunk is presented to the absorb stage.
REQ-008 out_ready  in  1  absorb stage consumes the chunk this cycle.
REQ-009 out_input_val  out  256  packed chunk; byte k of the chunk occupies bits [8k+7:8k].
REQ-010 out_input_length_bytes  out  7  number of valid bytes in the chunk, range 1..32.
REQ-011 out_absorb_round_num  out  8  chunk index within the current message, starting at 0.
REQ-012 out_last  out  1  chunk holds the final message byte.
REQ-013 err_round_overflow  out  1  sticky flag: message exceeded 256 chunks.

Function
REQ-014 A byte transfers when in_valid and in_ready are both 1 on a clock edge; a chunk transfers when out_valid and out_ready are both 1.
REQ-015 FSM has exactly two states, FILL and HOLD; reset enters FILL.
REQ-016 In FILL: in_ready=1, out_valid=0; each byte transfer writes the byte at the position given by byte_cnt (0..31), then increments byte_cnt.
REQ-017 FILL->HOLD on the byte transfer that is either the 32nd byte of the chunk or carries in_last=1; out_valid=1 on the next cycle (one-cycle latency).
REQ-018 In HOLD: in_ready=0, out_valid=1; all out_* stay stable until the chunk transfers.
REQ-019 out_input_length_bytes equals the number of bytes written to the chunk, which is 32 for every non-final chunk.
REQ-020 HOLD->FILL on chunk transfer; byte_cnt clears to 0.
REQ-021 On chunk transfer with out_last=0, the round counter increments; with out_last=1, it clears to 0 so the next message starts at round 0.
REQ-022 When in_last coincides with the 32nd byte, the feeder emits one chunk with length 32 and out_last=1; it never emits an empty chunk.
REQ-023 On transfer of a non-final chunk at round 255, err_round_overflow sets to 1 and the round counter saturates at 255; the flag clears only on reset.
REQ-024 While in HOLD, in_valid is ignored and no byte is lost, because the upstream source holds the byte under in_ready=0.

Reset
REQ-025 While reset_n=0 at a clock edge, the feeder enters FILL with byte_cnt=0, round=0, err_round_overflow=0, out_valid=0, and out_last=0.
REQ-026 Reset discards a partially filled or held chunk; the first byte accepted after reset is byte 0 of round 0.
REQ-027 After reset, out_input_val is all zero and out_input_length_bytes=0 until the first chunk is written.

Configuration
REQ-028 With EAGLESONG_FEEDER_ZERO_FILL_EN defined, the chunk buffer clears to zero on every chunk transfer, so unused bytes of a final chunk read as 0x00.
REQ-029 Without EAGLESONG_FEEDER_ZERO_FILL_EN, the buffer is not cleared, and unused bytes of a final chunk hold the previous chunk's contents; the downstream stage uses only out_input_length_bytes bytes.

Verification
REQ-030 "Hello, world!\n" (14 bytes, in_last on byte 14), ZERO_FILL on -> one chunk with val=256'h0A21646C726F77202C6F6C6C6548, len=14, round=0, last=1.
REQ-031 32 bytes [33,171,...,7,240] with in_last on byte 32 -> one chunk with val=256'hF0076FEA...075FAB21, len=32, round=0, last=1.
REQ-032 40-byte message, then a 3-byte message -> chunks (len32, r0, last0), (len8, r1, last1), then (len3, r0, last1).
REQ-033 out_ready held 0 for 5 cycles in HOLD -> in_ready=0 and out_* constant throughout; the chunk transfers on the first cycle out_ready=1, and in_ready=1 on the following cycle.
REQ-034 reset_n=0 for one cycle after 10 bytes of a message -> out_valid=0; a following 5-byte message gives len=5, round=0, with bytes at positions 0..4.
REQ-035 8193-byte message -> err_round_overflow=1 after the 256th chunk transfers; the final chunk reports round=255, len=1, last=1.

Source files
------------

// File: rtl/eaglesong_absorb_feeder.sv
// Packs a byte stream into 32-byte Eaglesong absorb chunks (length, round index, last flag).
// Optional macro EAGLESONG_FEEDER_ZERO_FILL_EN: clear the chunk buffer after every chunk transfer.
module eaglesong_absorb_feeder (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_input_val,
  output logic [6:0]   out_input_length_bytes,
  output logic [7:0]   out_absorb_round_num,
  output logic         out_last,
  output logic         err_round_overflow
);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]   state;
  logic [4:0]   byte_cnt;
  logic [255:0] chunk;
  logic [6:0]   len;
  logic [7:0]   round;
  logic         last;
  logic         err;

  logic byte_xfer;
  logic chunk_xfer;
  logic chunk_done;

  assign in_ready   = (state == FILL);
  assign out_valid  = (state == HOLD);
  assign byte_xfer  = in_valid & in_ready;
  assign chunk_xfer = out_valid & out_ready;
  // A full chunk and a final byte close the chunk the same way, so no empty chunk is ever emitted.
  assign chunk_done = byte_xfer & ((byte_cnt == 5'd31) | in_last);

  assign out_input_val          = chunk;
  assign out_input_length_bytes = len;
  assign out_absorb_round_num   = round;
  assign out_last               = last;
  assign err_round_overflow     = err;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= FILL;
      byte_cnt <= 5'd0;
      chunk    <= '0;
      len      <= 7'd0;
      round    <= 8'd0;
      last     <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (byte_xfer) begin
        chunk[{byte_cnt, 3'b000} +: 8] <= in_byte;
        byte_cnt                       <= byte_cnt + 5'd1;
      end
      if (chunk_done) begin
        state <= HOLD;
        len   <= {2'b00, byte_cnt} + 7'd1;
        last  <= in_last;
      end
      if (chunk_xfer) begin
        state    <= FILL;
        byte_cnt <= 5'd0;
`ifdef EAGLESONG_FEEDER_ZERO_FILL_EN
        chunk    <= '0;
`else
        chunk    <= chunk;
`endif
        // Round index restarts per message; a 257th chunk saturates and flags overflow.
        if (last) begin
          round <= 8'd0;
        end else if (round == 8'hFF) begin
          err <= 1'b1;
        end else begin
          round <= round + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eaglesong_absorb_feeder.sv
// Bench for eaglesong_absorb_feeder: message table, random handshakes, hold/reset/overflow sequences.
module tb_eaglesong_absorb_feeder;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_byte;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_input_val;
  logic [6:0]   out_input_length_bytes;
  logic [7:0]   out_absorb_round_num;
  logic         out_last;
  logic         err_round_overflow;

  always #5 clk = ~clk;

  eaglesong_absorb_feeder dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_input_val(out_input_val),
    .out_input_length_bytes(out_input_length_bytes), .out_absorb_round_num(out_absorb_round_num),
    .out_last(out_last), .err_round_overflow(err_round_overflow)
  );

  typedef struct {
    logic [255:0] val;
    int           len;
    int           round;
    bit           last;
    bit           err;
  } chunk_t;

  typedef struct {
    int len;
    int exp_chunks;
    int exp_last_len;
  } vec_t;

  int checks = 0;
  int fails  = 0;

  logic [7:0] mem [32];
  chunk_t     expq [$];
  bit         model_err;

  int           obs_cnt;
  int           obs_len;
  logic [255:0] obs_val;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Chunking from the byte sequence alone: 32-byte slices, round = min(index, 255).
  task automatic model_msg(input logic [7:0] msg [$]);
    int pos = 0;
    int idx = 0;
    chunk_t c;
    for (int i = 0; i < msg.size(); i++) begin
      mem[pos] = msg[i];
      pos++;
      if (pos == 32 || i == msg.size() - 1) begin
        for (int k = 0; k < 32; k++) c.val[8*k +: 8] = mem[k];
        c.len   = pos;
        c.round = (idx > 255) ? 255 : idx;
        c.last  = (i == msg.size() - 1);
        c.err   = model_err;
        expq.push_back(c);
        if (!c.last && idx >= 255) model_err = 1'b1;
`ifdef EAGLESONG_FEEDER_ZERO_FILL_EN
        for (int k = 0; k < 32; k++) mem[k] = 8'h00;
`endif
        idx++;
        pos = 0;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) mem[k] = 8'h00;
    expq.delete();
    model_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // One clock: drive at negedge, sample 1ns later, score any chunk transfer, then take the edge.
  task automatic step(input bit iv, input logic [7:0] b, input bit il, input bit ordy, output bit bx);
    chunk_t c;
    @(negedge clk);
    in_valid = iv; in_byte = b; in_last = il; out_ready = ordy;
    #1;
    bx = iv && in_ready;
    chk("ready_vs_valid", {255'd0, in_ready}, {255'd0, !out_valid});
    if (out_valid && ordy) begin
      if (expq.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_chunk: got len %0d expected no chunk", out_input_length_bytes);
      end else begin
        c = expq.pop_front();
        chk("chunk_val", out_input_val, c.val);
        chk("chunk_len", {249'd0, out_input_length_bytes}, 256'(c.len));
        chk("chunk_round", {248'd0, out_absorb_round_num}, 256'(c.round));
        chk("chunk_last", {255'd0, out_last}, {255'd0, c.last});
        chk("chunk_err", {255'd0, err_round_overflow}, {255'd0, c.err});
      end
      obs_cnt++;
      obs_len = out_input_length_bytes;
      obs_val = out_input_val;
    end
    @(posedge clk);
  endtask

  task automatic send_msg(input logic [7:0] msg [$], input int p_valid, input int p_ready);
    int i = 0;
    int budget = 40 * msg.size() + 200;
    bit bx;
    bit iv;
    model_msg(msg);
    obs_cnt = 0;
    while (i < msg.size() || expq.size() > 0) begin
      iv = (i < msg.size()) && ($urandom_range(99) < p_valid);
      step(iv, iv ? msg[i] : 8'h00, iv && (i == msg.size() - 1),
           $urandom_range(99) < p_ready, bx);
      if (bx) i++;
      budget--;
      if (budget == 0) begin
        checks++; fails++;
        $display("FAIL send_timeout: got %0d bytes sent, %0d chunks pending, required all done", i, expq.size());
        break;
      end
    end
    step(0, 8'h00, 0, 0, bx);
  endtask

  initial begin
    vec_t         vecs [9];
    logic [7:0]   msg [$];
    logic [255:0] snap_val;
    logic [6:0]   snap_len;
    logic [7:0]   snap_round;
    logic         snap_last;
    string        hello;
    bit           bx;

    vecs[0] = '{1, 1, 1};    vecs[1] = '{14, 1, 14};  vecs[2] = '{31, 1, 31};
    vecs[3] = '{32, 1, 32};  vecs[4] = '{33, 2, 1};   vecs[5] = '{64, 2, 32};
    vecs[6] = '{65, 3, 1};   vecs[7] = '{40, 2, 8};   vecs[8] = '{3, 1, 3};

    reset_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();
    #1;
    chk("rst_out_valid", {255'd0, out_valid}, 256'd0);
    chk("rst_in_ready", {255'd0, in_ready}, 256'd1);
    chk("rst_val", out_input_val, 256'd0);
    chk("rst_len", {249'd0, out_input_length_bytes}, 256'd0);
    chk("rst_round", {248'd0, out_absorb_round_num}, 256'd0);
    chk("rst_last", {255'd0, out_last}, 256'd0);
    chk("rst_err", {255'd0, err_round_overflow}, 256'd0);

    // Table of message lengths; 40 then 3 exercises round advance and restart.
    for (int v = 0; v < 9; v++) begin
      msg.delete();
      for (int k = 0; k < vecs[v].len; k++) msg.push_back(8'($urandom));
      send_msg(msg, (v % 2) ? 60 : 100, (v % 3) ? 50 : 100);
      chk("tbl_chunks", 256'(obs_cnt), 256'(vecs[v].exp_chunks));
      chk("tbl_last_len", 256'(obs_len), 256'(vecs[v].exp_last_len));
    end

    hello = "Hello, world!\n";
    msg.delete();
    for (int k = 0; k < hello.len(); k++) msg.push_back(hello[k]);
    send_msg(msg, 100, 100);
    chk("hello_bytes", {144'd0, obs_val[111:0]}, 256'h0A21646C726F77202C6F6C6C6548);
`ifdef EAGLESONG_FEEDER_ZERO_FILL_EN
    chk("hello_zero_fill", obs_val, 256'h0A21646C726F77202C6F6C6C6548);
`endif

    for (int r = 0; r < 20; r++) begin
      msg.delete();
      for (int k = 0; k < $urandom_range(100, 1); k++) msg.push_back(8'($urandom));
      send_msg(msg, $urandom_range(100, 20), $urandom_range(100, 20));
    end

    // Output held for five cycles of backpressure, then consumed.
    msg.delete();
    for (int k = 0; k < 5; k++) msg.push_back(8'($urandom));
    model_msg(msg);
    for (int k = 0; k < 5; k++) step(1, msg[k], k == 4, 0, bx);
    @(negedge clk);
    in_valid = 1'b1; in_byte = 8'hEE; in_last = 1'b0; out_ready = 1'b0;
    #1;
    chk("hold_valid", {255'd0, out_valid}, 256'd1);
    snap_val = out_input_val; snap_len = out_input_length_bytes;
    snap_round = out_absorb_round_num; snap_last = out_last;
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("hold_in_ready", {255'd0, in_ready}, 256'd0);
      chk("hold_val", out_input_val, snap_val);
      chk("hold_len", {249'd0, out_input_length_bytes}, {249'd0, snap_len});
      chk("hold_meta", {246'd0, out_absorb_round_num, out_last}, {246'd0, snap_round, snap_last});
      @(posedge clk);
    end
    step(0, 8'h00, 0, 1, bx);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("hold_release_ready", {255'd0, in_ready}, 256'd1);
    chk("hold_drained", 256'(expq.size()), 256'd0);

    // Reset in the middle of a message discards the partial chunk.
    for (int k = 0; k < 10; k++) step(1, 8'($urandom), 0, 1, bx);
    do_reset();
    #1;
    chk("midrst_out_valid", {255'd0, out_valid}, 256'd0);
    chk("midrst_val", out_input_val, 256'd0);
    msg.delete();
    for (int k = 0; k < 5; k++) msg.push_back(8'(k + 8'h51));
    send_msg(msg, 100, 100);
    chk("midrst_len", 256'(obs_len), 256'd5);
    chk("midrst_bytes", {216'd0, obs_val[39:0]}, 256'h5554535251);

    // 8193 bytes: 256 full chunks then one byte, round saturates at 255.
    msg.delete();
    for (int k = 0; k < 8193; k++) msg.push_back(8'($urandom));
    send_msg(msg, 100, 100);
    chk("ovf_chunks", 256'(obs_cnt), 256'd257);
    chk("ovf_last_len", 256'(obs_len), 256'd1);
    chk("ovf_err", {255'd0, err_round_overflow}, 256'd1);
    msg.delete();
    msg.push_back(8'h77);
    send_msg(msg, 100, 100);
    chk("ovf_sticky", {255'd0, err_round_overflow}, 256'd1);
    do_reset();
    #1;
    chk("ovf_cleared", {255'd0, err_round_overflow}, 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
